// File: rtl/ascon_perm_avalon_if.sv
// Avalon-MM slave bus bundle for the ASCON permutation block.
interface ascon_perm_avalon_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              iChip_select_n;
  logic              iRead_n;
  logic              iWrite_n;
  logic [ADDR_W-1:0] iAddress;
  logic [31:0]       iWriteData;
  logic [31:0]       oReadData;

  modport master (
    output iChip_select_n, iRead_n, iWrite_n, iAddress, iWriteData,
    input  oReadData
  );

  modport slave (
    input  iChip_select_n, iRead_n, iWrite_n, iAddress, iWriteData,
    output oReadData
  );
endinterface

// File: rtl/ascon_perm_avalon.sv
// ascon_perm_avalon: Avalon-MM slave holding a 320-bit ASCON state with an
// iterative permutation engine (UNROLL rounds per clock, 1..12 rounds/run).
// Optional feature macro: ASCON_IRQ_EN (adds oIrq and the CTRL.irq_en bit).
//
// state | meaning
// IDLE  | waiting for CTRL.start; OUT holds the last result
// RUN   | applying up to UNROLL rounds per clock to the working state
module ascon_perm_avalon #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned UNROLL   = 1,
  parameter int unsigned DEF_RNDS = 12,
  parameter logic [31:0] VERSION  = 32'h0002_0000
) (
  input  logic               iClk,
  input  logic               iReset_n,
  ascon_perm_avalon_if.slave bus
`ifdef ASCON_IRQ_EN
  ,
  output logic               oIrq
`endif
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef logic [4:0][63:0] ascon_st_t;

  state_t            state_q;
  ascon_st_t         in_q, out_q, work_q, work_d;
  logic [3:0]        rem_q, k_q, rounds_q, n_d, wr_rnds;
  logic              done_q, ovr_q, err_q, irq_en_rd;
  logic [31:0]       rdata_q, rmux;
  logic [ADDR_W-1:0] addr;
  logic              wr_en, rd_en, start, rnd_ok;

  assign addr          = bus.iAddress;
  assign wr_en         = !bus.iChip_select_n && !bus.iWrite_n;
  assign rd_en         = !bus.iChip_select_n && !bus.iRead_n && bus.iWrite_n;
  assign start         = wr_en && (addr == ADDR_W'(0)) && bus.iWriteData[0];
  assign wr_rnds       = bus.iWriteData[11:8];
  assign rnd_ok        = (wr_rnds != 4'd0) && (wr_rnds <= 4'd12);
  assign bus.oReadData = rdata_q;

`ifdef ASCON_IRQ_EN
  logic irq_en_q;
  assign irq_en_rd = irq_en_q;
  assign oIrq      = done_q & irq_en_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One ASCON round; k is the absolute round index (0..11) selecting the constant.
  function automatic ascon_st_t round_f(input ascon_st_t s, input logic [3:0] k);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = 8'hF0 - ({4'h0, k} * 8'h0F);
    x0 = s[0];
    x1 = s[1];
    x2 = s[2] ^ {56'h0, c};
    x3 = s[3];
    x4 = s[4];
    // bitsliced form of the 5-bit S-box, x0 is the column MSB
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror64(x0, 19) ^ ror64(x0, 28);
    x1 ^= ror64(x1, 61) ^ ror64(x1, 39);
    x2 ^= ror64(x2, 1)  ^ ror64(x2, 6);
    x3 ^= ror64(x3, 10) ^ ror64(x3, 17);
    x4 ^= ror64(x4, 7)  ^ ror64(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  // Chain up to UNROLL rounds, stopping early once the remaining count runs out.
  always_comb begin
    work_d = work_q;
    n_d    = 4'd0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      if (4'(i) < rem_q) begin
        work_d = round_f(work_d, k_q + 4'(i));
        n_d    = n_d + 4'd1;
      end
    end
  end

  // Register read multiplexer; unmapped addresses read 0.
  always_comb begin
    rmux = 32'h0;
    if (addr == ADDR_W'(0))  rmux = {20'h0, rounds_q, 6'h0, irq_en_rd, 1'b0};
    if (addr == ADDR_W'(21)) rmux = {28'h0, err_q, ovr_q, done_q, state_q == S_RUN};
    if (addr == ADDR_W'(22)) rmux = VERSION;
    for (int i = 0; i < 5; i++) begin
      if (addr == ADDR_W'(2*i + 1))  rmux = in_q[i][31:0];
      if (addr == ADDR_W'(2*i + 2))  rmux = in_q[i][63:32];
      if (addr == ADDR_W'(2*i + 11)) rmux = out_q[i][31:0];
      if (addr == ADDR_W'(2*i + 12)) rmux = out_q[i][63:32];
    end
  end

  // Bus register writes, read-data register and the run/idle sequencer.
  // Sticky status bits are cleared before being set so a same-edge set wins.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q  <= S_IDLE;
      in_q     <= '0;
      out_q    <= '0;
      work_q   <= '0;
      rem_q    <= 4'd0;
      k_q      <= 4'd0;
      rounds_q <= 4'(DEF_RNDS);
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
`ifdef ASCON_IRQ_EN
      irq_en_q <= 1'b0;
`endif
    end else begin
      if (rd_en) rdata_q <= rmux;
      if (wr_en) begin
        for (int i = 0; i < 5; i++) begin
          if (addr == ADDR_W'(2*i + 1)) in_q[i][31:0]  <= bus.iWriteData;
          if (addr == ADDR_W'(2*i + 2)) in_q[i][63:32] <= bus.iWriteData;
        end
        if (addr == ADDR_W'(0)) begin
          rounds_q <= wr_rnds;
`ifdef ASCON_IRQ_EN
          irq_en_q <= bus.iWriteData[1];
`endif
        end
        if (addr == ADDR_W'(21)) begin
          if (bus.iWriteData[1]) done_q <= 1'b0;
          if (bus.iWriteData[2]) ovr_q  <= 1'b0;
          if (bus.iWriteData[3]) err_q  <= 1'b0;
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (rnd_ok) begin
              work_q  <= in_q;
              rem_q   <= wr_rnds;
              k_q     <= 4'd12 - wr_rnds;
              state_q <= S_RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (start) ovr_q <= 1'b1;
          work_q <= work_d;
          rem_q  <= rem_q - n_d;
          k_q    <= k_q + n_d;
          if (rem_q == n_d) begin
            out_q   <= work_d;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_perm_avalon.sv
// Self-checking bench for ascon_perm_avalon: directed sequence plus random
// states/round counts checked against a table-driven ASCON model.
module tb_ascon_perm_avalon;
  localparam int UNROLL = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0, checks = 0, errors = 0, start_cyc = 0;

  ascon_perm_avalon_if #(.ADDR_W(5)) bif ();
`ifdef ASCON_IRQ_EN
  logic irq;
`endif

  ascon_perm_avalon #(
    .ADDR_W(5), .UNROLL(UNROLL), .DEF_RNDS(12), .VERSION(32'h0002_0000)
  ) dut (
    .iClk(clk), .iReset_n(rst_n), .bus(bif)
`ifdef ASCON_IRQ_EN
    , .oIrq(irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: S-box as a lookup table over 5-bit columns (x0 = MSB).
  int sbox_lut [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                        30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [4:0][63:0] model_perm(input logic [4:0][63:0] s_in, input int nr);
    logic [4:0][63:0] s, t;
    logic [4:0] v, o;
    s = s_in;
    for (int r = 12 - nr; r < 12; r++) begin
      s[2][7:0] = s[2][7:0] ^ 8'(((15 - r) << 4) | r);
      t = '0;
      for (int j = 0; j < 64; j++) begin
        v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
        o = 5'(sbox_lut[v]);
        for (int w = 0; w < 5; w++) t[w][j] = o[4 - w];
      end
      for (int w = 0; w < 5; w++) s[w] = t[w] ^ rotr(t[w], rot_a[w]) ^ rotr(t[w], rot_b[w]);
    end
    return s;
  endfunction

  logic [4:0][63:0] in_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bif.iChip_select_n = 1'b1;
    bif.iRead_n        = 1'b1;
    bif.iWrite_n       = 1'b1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bif.iChip_select_n = 1'b0; bif.iWrite_n = 1'b0; bif.iRead_n = 1'b1;
    bif.iAddress = 5'(a); bif.iWriteData = d;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    bif.iChip_select_n = 1'b0; bif.iRead_n = 1'b0; bif.iWrite_n = 1'b1;
    bif.iAddress = 5'(a);
    @(posedge clk); #1;
    d = bif.oReadData;
    bus_idle();
  endtask

  task automatic rd_check(input string tag, input int a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic load_in(input logic [4:0][63:0] s);
    for (int i = 0; i < 5; i++) begin
      wr(2*i + 1, s[i][31:0]);
      wr(2*i + 2, s[i][63:32]);
    end
    in_m = s;
  endtask

  task automatic start(input int rounds, input logic irq_en);
    wr(0, {20'h0, 4'(rounds), 6'h0, irq_en, 1'b1});
    start_cyc = cyc;
  endtask

  // Polls STATUS every cycle; lat is the edge count from start to completion.
  task automatic run_wait(output int lat, output int nbusy);
    logic [31:0] d;
    lat = -1;
    nbusy = 0;
    for (int g = 0; g < 100; g++) begin
      rd(21, d);
      if (d[0]) nbusy++;
      else begin
        lat = cyc - 1 - start_cyc;
        break;
      end
    end
  endtask

  task automatic check_out(input string tag, input logic [4:0][63:0] exp);
    for (int i = 0; i < 5; i++) begin
      rd_check($sformatf("%s_x%0dlo", tag, i), 2*i + 11, exp[i][31:0]);
      rd_check($sformatf("%s_x%0dhi", tag, i), 2*i + 12, exp[i][63:32]);
    end
  endtask

  initial begin
    logic [4:0][63:0] tv, exp;
    logic [31:0] d;
    int lat, nbusy, nr;

    bus_idle();
    bif.iAddress   = '0;
    bif.iWriteData = '0;
    in_m = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset values
    rd_check("rst_ctrl", 0, 32'h0000_0C00);
    rd_check("rst_status", 21, 32'h0);
    rd_check("rst_version", 22, 32'h0002_0000);
    check_out("rst_out", '0);

    // p12 on the reference vector
    tv[0] = 64'h0123456789ABCDEF; tv[1] = 64'hFEDCBA9876543210;
    tv[2] = 64'h1234567890ABCDEF; tv[3] = 64'hA1B2C3D4E5F60789;
    tv[4] = 64'h1111111111111111;
    load_in(tv);
    rd_check("in_x2hi", 6, 32'h12345678);
    start(12, 1'b0);
    run_wait(lat, nbusy);
    check("p12_latency", 32'(lat), 32'((12 + UNROLL - 1) / UNROLL));
    check("p12_busy_cycles", 32'(nbusy), 32'((12 + UNROLL - 1) / UNROLL));
    rd_check("p12_status", 21, 32'h2);
    check_out("p12", model_perm(in_m, 12));

    // p6 with an extra start while running
    start(6, 1'b0);
    rd(21, d);
    check("p6_busy", {31'h0, d[0]}, 32'h1);
    wr(0, 32'h0000_0601);
    run_wait(lat, nbusy);
    check("p6_latency", 32'(lat), 32'((6 + UNROLL - 1) / UNROLL));
    rd_check("p6_status_ovr", 21, 32'h6);
    check_out("p6", model_perm(in_m, 6));

    // unmapped address and read-only OUT
    wr(25, 32'hDEAD_BEEF);
    rd_check("unmapped_read", 25, 32'h0);
    wr(11, 32'hDEAD_BEEF);
    exp = model_perm(in_m, 6);
    rd_check("out_ro", 11, exp[0][31:0]);

    // illegal round counts
    wr(21, 32'hE);
    rd_check("status_w1c", 21, 32'h0);
    wr(0, 32'h0000_0001);
    rd_check("rnd0_status", 21, 32'h8);
    wr(21, 32'h8);
    rd_check("err_clear", 21, 32'h0);
    wr(0, 32'h0000_0D01);
    rd_check("rnd13_status", 21, 32'h8);
    wr(21, 32'h8);

    // interrupt enable
    wr(0, 32'h0000_0C02);
`ifdef ASCON_IRQ_EN
    rd_check("ctrl_irq_en", 0, 32'h0000_0C02);
    check("irq_idle", {31'h0, irq}, 32'h0);
    start(12, 1'b1);
    run_wait(lat, nbusy);
    check("irq_latency", 32'(lat), 32'((12 + UNROLL - 1) / UNROLL));
    check("irq_high", {31'h0, irq}, 32'h1);
    wr(21, 32'h2);
    check("irq_low", {31'h0, irq}, 32'h0);
`else
    rd_check("ctrl_irq_en", 0, 32'h0000_0C00);
`endif

    // reset in the middle of a run
    wr(21, 32'hE);
    start(12, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #2 check("rst_rdata", bif.oReadData, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_m = '0;
    rd_check("abort_status", 21, 32'h0);
    rd_check("abort_ctrl", 0, 32'h0000_0C00);
    check_out("abort_out", '0);
    start(12, 1'b0);
    run_wait(lat, nbusy);
    check("fresh_latency", 32'(lat), 32'((12 + UNROLL - 1) / UNROLL));
    check_out("fresh", model_perm(in_m, 12));

    // random states and round counts
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 5; i++) tv[i] = {$urandom, $urandom};
      nr = $urandom_range(1, 12);
      load_in(tv);
      start(nr, 1'b0);
      run_wait(lat, nbusy);
      check($sformatf("rnd%0d_latency", it), 32'(lat), 32'((nr + UNROLL - 1) / UNROLL));
      rd_check($sformatf("rnd%0d_status", it), 21, 32'h2);
      check_out($sformatf("rnd%0d", it), model_perm(in_m, nr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
